// File: rtl/hack_mux_pkg.sv
// hack_mux_pkg: definitions shared by the 8-way arbitrating multiplexer
// (mux8way_arbiter), its bus interface and its priority encoder.
//   NUM_CH  number of source channels
//   SEL_W   width of a channel index
//   WORD_W  Hack word width
//   sel_t   channel index type
//   state_t output register occupancy (EMPTY / FULL)
package hack_mux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int WORD_W = 16;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux8way_arbiter_if.sv
// mux8way_arbiter_if: bundles the eight source handshakes and the single
// registered sink handshake of mux8way_arbiter.
//   in_valid  [NUM_CH]        channel i presents a word
//   in_data   [NUM_CH*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_ready  [NUM_CH]        one-hot or zero, channel i word consumed
//   out_valid                 output register holds a word
//   out_data  [WIDTH]         registered winning word
//   out_sel   [SEL_W]         index of the channel that supplied out_data
//   out_ready                 sink accepts out_data this cycle
// Modports: master = sources and sink side, slave = arbiter side.
interface mux8way_arbiter_if
    import hack_mux_pkg::*;
#(
    parameter int WIDTH = WORD_W
);

    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    sel_t                    out_sel;
    logic                    out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

endinterface

// File: rtl/rr_pick8.sv
// rr_pick8: combinational rotating-priority encoder over eight requests.
// The search starts at index 'start' and walks upward with wrap-around;
// the first asserted request wins. With start tied to 0 it degenerates
// into a plain fixed-priority encoder (bit 0 highest).
//   req     in   8  request vector
//   start   in   3  first index examined
//   found   out  1  at least one request asserted
//   winner  out  3  index of the chosen request (0 when found is low)
module rr_pick8
    import hack_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              start,
    output logic              found,
    output sel_t              winner
);

    sel_t idx;

    // Walk the eight positions from 'start'; the 3-bit index wraps naturally.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = start + sel_t'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: eight-to-one arbitrating multiplexer for Hack word
// streams. One source is granted per cycle, its word is registered, and the
// winning channel index is presented on out_sel so a downstream 8-way demux
// can route a reply back to the originator.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    mux8way_arbiter_if.slave (source and sink handshakes)
// Build option MUX8WAY_RR_EN: when defined, the grant uses rotating priority
// starting just after the last granted channel; when undefined, channel 0 has
// fixed highest priority and no last-grant state exists.
module mux8way_arbiter
    import hack_mux_pkg::*;
#(
    parameter int WIDTH = WORD_W
)(
    input  logic                    clk,
    input  logic                    rst_n,
    mux8way_arbiter_if.slave        bus
);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  data_q;
    sel_t              sel_q;
    logic              load_en;
    logic              grant;
    logic              found;
    sel_t              winner;
    sel_t              start;
    logic [NUM_CH-1:0] in_ready_c;

`ifdef MUX8WAY_RR_EN
    sel_t              last_sel_q;

    // Search begins one past the previous winner; resets to 7 so channel 0 leads.
    assign start = last_sel_q + sel_t'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sel_q <= sel_t'(NUM_CH - 1);
        end else if (grant) begin
            last_sel_q <= winner;
        end
    end
`else
    assign start = '0;
`endif

    rr_pick8 u_pick (
        .req    (bus.in_valid),
        .start  (start),
        .found  (found),
        .winner (winner)
    );

    // Grant and next-state logic. rst_n gates the grant so in_ready stays
    // low for the whole reset, not just after the register has cleared.
    always_comb begin
        load_en    = (state_q == ST_EMPTY) || bus.out_ready;
        grant      = rst_n && load_en && found;
        in_ready_c = '0;
        state_d    = state_q;
        if (grant) begin
            in_ready_c[winner] = 1'b1;
        end
        unique case (state_q)
            ST_EMPTY: state_d = grant ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (bus.out_ready) begin
                    state_d = grant ? ST_FULL : ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output register; data and index only change on a grant, so they hold
    // through stalls and through an empty cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                data_q <= bus.in_data[winner*WIDTH +: WIDTH];
                sel_q  <= winner;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux8way_arbiter.sv
// tb_mux8way_arbiter: directed bench for mux8way_arbiter. Inputs are driven
// 2 ns after each rising edge; combinational in_ready is sampled 1 ns after
// driving, registered outputs right after the edge settles.
// Build option MUX8WAY_RR_EN selects the rotating-priority scenarios,
// otherwise the fixed-priority scenario runs.
module tb_mux8way_arbiter;
    import hack_mux_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux8way_arbiter_if #(.WIDTH(WORD_W)) bus ();

    mux8way_arbiter #(.WIDTH(WORD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input int ch, input logic [WORD_W-1:0] w);
        bus.in_data[ch*WORD_W +: WORD_W] = w;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        step();
        #1;
        total++;
        if (bus.in_ready !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_in_ready_low: got %h want 00", bus.in_ready);
        end
        bus.in_valid = '0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b0 || bus.out_sel !== 3'd0 ||
                bus.out_data !== 16'h0000 || bus.in_ready !== 8'h00) begin
                bad++;
                $display("[TB] FAIL reset_idle c%0d: got v=%b sel=%0d data=%h rdy=%h want v=0 sel=0 data=0000 rdy=00",
                         c, bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready = 1'b1;
        set_word(5, 16'h1234);
        bus.in_valid = 8'b0010_0000;
        #1;
        total++;
        if (bus.in_ready !== 8'b0010_0000) begin
            bad++;
            $display("[TB] FAIL single_in_ready: got %b want 00100000", bus.in_ready);
        end
        step();
        bus.in_valid = '0;
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234 || bus.out_sel !== 3'd5) begin
            bad++;
            $display("[TB] FAIL single_out: got v=%b data=%h sel=%0d want v=1 data=1234 sel=5",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        total++;
        if (bus.in_ready !== 8'h00) begin
            bad++;
            $display("[TB] FAIL single_ready_once: got %h want 00", bus.in_ready);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_drain: got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'd0;
        exp_sel[1] = 3'd1;
        exp_sel[2] = 3'd2;
        do_reset();
        bus.out_ready = 1'b1;
        set_word(0, 16'hA000);
        set_word(1, 16'hA001);
        set_word(2, 16'hA002);
        bus.in_valid = 8'b0000_0111;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.in_valid[exp_sel[k]] = 1'b0;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[k] ||
                bus.out_data !== (16'hA000 | 16'(exp_sel[k]))) begin
                bad++;
                $display("[TB] FAIL b2b_word%0d: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         k, bus.out_valid, bus.out_sel, bus.out_data, exp_sel[k],
                         16'hA000 | 16'(exp_sel[k]));
            end
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_no_dup: got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_word(2, 16'h2222);
        set_word(6, 16'h6666);
        bus.in_valid  = 8'b0100_0100;
        bus.out_ready = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 8'b0000_0100) begin
            bad++;
            $display("[TB] FAIL bp_first_grant: got %b want 00000100", bus.in_ready);
        end
        step();
        bus.in_valid = 8'b0100_0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h2222 ||
                bus.out_sel !== 3'd2 || bus.in_ready !== 8'h00) begin
                bad++;
                $display("[TB] FAIL bp_stall c%0d: got v=%b data=%h sel=%0d rdy=%h want v=1 data=2222 sel=2 rdy=00",
                         c, bus.out_valid, bus.out_data, bus.out_sel, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 8'b0100_0000) begin
            bad++;
            $display("[TB] FAIL bp_release_grant: got %b want 01000000", bus.in_ready);
        end
        step();
        bus.in_valid = '0;
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h6666 || bus.out_sel !== 3'd6) begin
            bad++;
            $display("[TB] FAIL bp_second_word: got v=%b data=%h sel=%0d want v=1 data=6666 sel=6",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_no_dup: got v=%b want 0", bus.out_valid);
        end
    endtask

`ifdef MUX8WAY_RR_EN
    task automatic test_round_robin();
        logic [7:0] exp_rdy;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            set_word(i, 16'h0100 + 16'(i));
        end
        bus.in_valid = 8'hFF;
        #1;
        total++;
        if (bus.in_ready !== 8'h01) begin
            bad++;
            $display("[TB] FAIL rr_first_grant: got %h want 01", bus.in_ready);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            #1;
            exp_rdy = 8'h01 << ((k + 1) % 8);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'(k % 8) ||
                bus.out_data !== 16'h0100 + 16'(k % 8) || bus.in_ready !== exp_rdy) begin
                bad++;
                $display("[TB] FAIL rr_seq k%0d: got v=%b sel=%0d data=%h rdy=%h want v=1 sel=%0d data=%h rdy=%h",
                         k, bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready,
                         k % 8, 16'h0100 + 16'(k % 8), exp_rdy);
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [2:0] exp_sel;
        do_reset();
        bus.out_ready = 1'b1;
        set_word(1, 16'h1111);
        set_word(3, 16'h3333);
        bus.in_valid = 8'b0000_1010;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_sel = (k % 2 == 0) ? 3'd1 : 3'd3;
            total++;
            if (bus.out_sel !== exp_sel) begin
                bad++;
                $display("[TB] FAIL rr_alternate k%0d: got sel=%0d want %0d", k, bus.out_sel, exp_sel);
            end
        end
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        bus.out_ready = 1'b1;
        set_word(1, 16'h1111);
        set_word(3, 16'h3333);
        bus.in_valid = 8'b0000_1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (bus.in_ready !== 8'b0000_0010) begin
                bad++;
                $display("[TB] FAIL fixed_ch1_wins k%0d: got %b want 00000010", k, bus.in_ready);
            end
            step();
            total++;
            if (bus.out_sel !== 3'd1 || bus.out_data !== 16'h1111) begin
                bad++;
                $display("[TB] FAIL fixed_out k%0d: got sel=%0d data=%h want sel=1 data=1111",
                         k, bus.out_sel, bus.out_data);
            end
        end
        bus.in_valid = 8'b0000_1000;
        #1;
        total++;
        if (bus.in_ready !== 8'b0000_1000) begin
            bad++;
            $display("[TB] FAIL fixed_ch3_after: got %b want 00001000", bus.in_ready);
        end
        step();
        total++;
        if (bus.out_sel !== 3'd3 || bus.out_data !== 16'h3333) begin
            bad++;
            $display("[TB] FAIL fixed_ch3_out: got sel=%0d data=%h want sel=3 data=3333",
                     bus.out_sel, bus.out_data);
        end
    endtask
`endif

    task automatic test_reset_mid_stall();
        do_reset();
        set_word(4, 16'h4444);
        bus.in_valid  = 8'b0001_0000;
        bus.out_ready = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 8'b0001_0000) begin
            bad++;
            $display("[TB] FAIL ms_load: got %b want 00010000", bus.in_ready);
        end
        step();
        set_word(3, 16'h3333);
        set_word(6, 16'h6666);
        bus.in_valid = 8'b0100_1000;
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd4 || bus.in_ready !== 8'h00) begin
            bad++;
            $display("[TB] FAIL ms_stalled: got v=%b sel=%0d rdy=%h want v=1 sel=4 rdy=00",
                     bus.out_valid, bus.out_sel, bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 ||
            bus.out_sel !== 3'd0 || bus.in_ready !== 8'h00) begin
            bad++;
            $display("[TB] FAIL ms_async_reset: got v=%b data=%h sel=%0d rdy=%h want v=0 data=0000 sel=0 rdy=00",
                     bus.out_valid, bus.out_data, bus.out_sel, bus.in_ready);
        end
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 8'b0000_1000) begin
            bad++;
            $display("[TB] FAIL ms_first_grant: got %b want 00001000", bus.in_ready);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd3 || bus.out_data !== 16'h3333) begin
            bad++;
            $display("[TB] FAIL ms_after_reset: got v=%b sel=%0d data=%h want v=1 sel=3 data=3333",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
`ifdef MUX8WAY_RR_EN
        test_round_robin();
        test_rr_fairness();
`else
        test_fixed_priority();
`endif
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
